sht10_convert: RTL and testbench



---
 rtl/sht10_pkg.sv | 23 ++
 rtl/sht10_bin2bcd.sv | 51 +++++
 rtl/sht10_convert.sv | 189 ++++++++++++++++++
 tb/tb_sht10_convert.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sht10_pkg.sv
// Shared definitions for the SHT10 raw-sample converter:
// FSM encoding, calibration coefficients and sequencing lengths.
package sht10_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARITH,
      S_CLAMP,
      S_BCD,
      S_DONE
   } state_e;

   localparam int T_OFFSET  = 3970;
   localparam int C_RH1     = 6157238;
   localparam int C_RH2     = 268;
   localparam int C_RH0     = 343396057;
   localparam int RH_SHIFT  = 24;

   localparam int ARITH_CYC = 16;
   localparam int BCD_CYC   = 11;

endpackage

// File: rtl/sht10_bin2bcd.sv
// Sequential double-dabble: 11-bit binary to four BCD digits,
// one bit per cycle, done pulses with the final shift.
module sht10_bin2bcd
   import sht10_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start_i,
   input  logic [10:0] bin_i,
   output logic [15:0] bcd_o,
   output logic        done_o
);

   logic [10:0] bin_q;
   logic [15:0] bcd_q;
   logic [15:0] adj_w;
   logic [3:0]  cnt_q;
   logic        done_q;

   always_comb begin
      adj_w = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            adj_w[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (start_i) begin
         bin_q  <= bin_i;
         bcd_q  <= '0;
         cnt_q  <= 4'(BCD_CYC);
         done_q <= 1'b0;
      end else if (cnt_q != 4'd0) begin
         {bcd_q, bin_q} <= {adj_w, bin_q} << 1;
         cnt_q  <= cnt_q - 4'd1;
         done_q <= (cnt_q == 4'd1);
      end else begin
         done_q <= 1'b0;
      end
   end

   assign bcd_o  = bcd_q;
   assign done_o = done_q;

endmodule

// File: rtl/sht10_convert.sv
// SHT10 raw word to calibrated tenths and BCD, fixed 30-cycle
// latency with busy/overrun handshake toward the sensor side.
module sht10_convert
   import sht10_pkg::*;
#(
   parameter int T_D1X10 = T_OFFSET / 10,
   parameter int RH_MAX  = 1000
)(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        raw_valid,
   input  logic        raw_sel,
   input  logic [13:0] raw_data,
   output logic        busy,
   output logic        out_valid,
   output logic        out_sel,
   output logic        neg,
   output logic        clamped,
   output logic [15:0] bcd,
   output logic        overrun
);

   localparam logic [15:0]        T_OFF = 16'(T_D1X10 * 10);
   localparam logic signed [35:0] RH_HI = 36'(RH_MAX);

   state_e             state_q;
   logic               sel_q;
   logic [13:0]        data_q;
   logic [4:0]         cnt_q;
   logic signed [35:0] acc_q;
   logic [35:0]        mcand_q;
   logic [11:0]        mplier_q;
   logic [15:0]        dvd_q;
   logic [3:0]         rem_q;
   logic               tneg_q;
   logic               rneg_q;
   logic               rclp_q;
   logic               busy_q;
   logic               ovalid_q;
   logic               osel_q;
   logic               oneg_q;
   logic               oclp_q;
   logic               ovr_q;
   logic [15:0]        obcd_q;

   logic [15:0]        diff_w;
   logic [15:0]        abs_w;
   logic [11:0]        so_w;
   logic [35:0]        mcand_d;
   logic [4:0]         rtry_w;
   logic               qbit_w;
   logic [3:0]         rem_w;
   logic signed [35:0] rh_w;
   logic [10:0]        mag_d;
   logic               neg_d;
   logic               clp_d;
   logic [15:0]        bcd_w;
   logic               bcd_done_w;
   logic               unused_w;

   assign diff_w  = {2'b00, data_q} - T_OFF;
   assign abs_w   = diff_w[15] ? 16'(-diff_w) : diff_w;
   assign so_w    = data_q[11:0];
   assign mcand_d = 36'(C_RH1) - 36'(C_RH2) * 36'(so_w);

   // Restoring division by 10, one quotient bit per ARITH cycle
   assign rtry_w  = {rem_q, dvd_q[15]};
   assign qbit_w  = (rtry_w >= 5'd10);
   assign rem_w   = 4'(qbit_w ? rtry_w - 5'd10 : rtry_w);

   assign rh_w    = acc_q >>> RH_SHIFT;
   assign unused_w = ^acc_q[23:0];

   always_comb begin
      mag_d = dvd_q[10:0];
      neg_d = tneg_q && (dvd_q != 16'd0);
      clp_d = 1'b0;
      if (sel_q) begin
         neg_d = 1'b0;
         if (rh_w < 36'sd0) begin
            mag_d = '0;
            clp_d = 1'b1;
         end else if (rh_w > RH_HI) begin
            mag_d = 11'(RH_MAX);
            clp_d = 1'b1;
         end else begin
            mag_d = rh_w[10:0];
         end
      end
   end

   sht10_bin2bcd u_bcd (
      .clock   (clock),
      .reset_n (reset_n),
      .start_i (state_q == S_CLAMP),
      .bin_i   (mag_d),
      .bcd_o   (bcd_w),
      .done_o  (bcd_done_w)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         sel_q    <= 1'b0;
         data_q   <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         dvd_q    <= '0;
         rem_q    <= '0;
         tneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         rclp_q   <= 1'b0;
         busy_q   <= 1'b0;
         ovalid_q <= 1'b0;
         osel_q   <= 1'b0;
         oneg_q   <= 1'b0;
         oclp_q   <= 1'b0;
         ovr_q    <= 1'b0;
         obcd_q   <= '0;
      end else begin
         ovr_q    <= raw_valid && (state_q != S_IDLE);
         busy_q   <= (state_q != S_IDLE) || raw_valid;
         ovalid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (raw_valid) begin
                  sel_q   <= raw_sel;
                  data_q  <= raw_data;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               dvd_q    <= abs_w;
               rem_q    <= '0;
               tneg_q   <= diff_w[15];
               acc_q    <= 36'sd0 - 36'(C_RH0);
               mcand_q  <= mcand_d;
               mplier_q <= so_w;
               cnt_q    <= 5'(ARITH_CYC - 1);
               state_q  <= S_ARITH;
            end
            S_ARITH: begin
               dvd_q    <= {dvd_q[14:0], qbit_w};
               rem_q    <= rem_w;
               if (mplier_q[0])
                  acc_q <= acc_q + $signed(mcand_q);
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               if (cnt_q == 5'd0)
                  state_q <= S_CLAMP;
               else
                  cnt_q <= cnt_q - 5'd1;
            end
            S_CLAMP: begin
               rneg_q  <= neg_d;
               rclp_q  <= clp_d;
               cnt_q   <= 5'(BCD_CYC - 1);
               state_q <= S_BCD;
            end
            S_BCD: begin
               if (cnt_q == 5'd0)
                  state_q <= S_DONE;
               else
                  cnt_q <= cnt_q - 5'd1;
            end
            S_DONE: begin
               obcd_q   <= bcd_w;
               oneg_q   <= rneg_q;
               oclp_q   <= rclp_q;
               osel_q   <= sel_q;
               ovalid_q <= bcd_done_w;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign out_valid = ovalid_q;
   assign out_sel   = osel_q;
   assign neg       = oneg_q;
   assign clamped   = oclp_q;
   assign bcd       = obcd_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_sht10_convert.sv
// Bench for sht10_convert: directed, random, overrun,
// back-to-back and mid-conversion reset scenarios.
module tb_sht10_convert;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        raw_valid = 1'b0;
   logic        raw_sel = 1'b0;
   logic [13:0] raw_data = '0;
   logic        busy, out_valid, out_sel, neg, clamped, overrun;
   logic [15:0] bcd;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   sht10_convert dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .raw_valid (raw_valid),
      .raw_sel   (raw_sel),
      .raw_data  (raw_data),
      .busy      (busy),
      .out_valid (out_valid),
      .out_sel   (out_sel),
      .neg       (neg),
      .clamped   (clamped),
      .bcd       (bcd),
      .overrun   (overrun)
   );

   // Reference: calibration formulas in plain integer arithmetic
   function automatic void model(input bit sel, input logic [13:0] d,
                                 output logic [15:0] eb,
                                 output bit en, output bit ec);
      longint so, acc, rh;
      int t, v;
      en = 0;
      ec = 0;
      if (!sel) begin
         t = int'(d) - 3970;
         v = (t < 0 ? -t : t) / 10;
         en = (t < 0) && (v != 0);
      end else begin
         so = longint'(d[11:0]);
         acc = 6157238 * so - 268 * so * so - 343396057;
         rh = acc >>> 24;
         if (rh < 0) begin
            v = 0;
            ec = 1;
         end else if (rh > 1000) begin
            v = 1000;
            ec = 1;
         end else begin
            v = int'(rh);
         end
      end
      eb = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic strobe(input bit sel, input logic [13:0] d);
      @(negedge clock);
      raw_valid = 1'b1;
      raw_sel = sel;
      raw_data = d;
      @(posedge clock);
      #1;
      raw_valid = 1'b0;
   endtask

   task automatic run_one(input bit sel, input logic [13:0] d,
                          output int lat);
      strobe(sel, d);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      total++;
      if ({busy, out_valid, overrun, neg, clamped, out_sel} !== 6'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=000000",
                  {busy, out_valid, overrun, neg, clamped, out_sel});
      end
      total++;
      if (bcd !== 16'h0000) begin
         bad++;
         $display("FAIL reset_bcd got=%h exp=0000", bcd);
      end
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL post_reset busy=%b ov=%b exp 0 0", busy, out_valid);
      end
   endtask

   task automatic test_directed();
      bit          ds[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
      int          dd[8] = '{6000, 0, 16383, 3965, 1000, 4095, 0, 13288};
      logic [15:0] db[8] = '{16'h0203, 16'h0397, 16'h1241, 16'h0000,
                             16'h0330, 16'h1000, 16'h0000, 16'h0330};
      bit          dn[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
      bit          dc[8] = '{0, 0, 0, 0, 0, 1, 1, 0};
      int lat;
      for (int k = 0; k < 8; k++) begin
         run_one(ds[k], 14'(dd[k]), lat);
         total++;
         if (lat !== 30) begin
            bad++;
            $display("FAIL dir%0d latency got=%0d exp=30", k, lat);
         end
         total++;
         if (bcd !== db[k]) begin
            bad++;
            $display("FAIL dir%0d bcd got=%h exp=%h", k, bcd, db[k]);
         end
         total++;
         if (neg !== dn[k] || clamped !== dc[k] || out_sel !== ds[k]) begin
            bad++;
            $display("FAIL dir%0d n/c/s got=%b%b%b exp=%b%b%b", k,
                     neg, clamped, out_sel, dn[k], dc[k], ds[k]);
         end
         if (k == 0) begin
            @(posedge clock);
            #1;
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || bcd !== db[k]) begin
               bad++;
               $display("FAIL dir_after ov=%b busy=%b bcd=%h exp 0 0 %h",
                        out_valid, busy, bcd, db[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] eb;
      bit en, ec, s;
      logic [13:0] d;
      int lat;
      for (int k = 0; k < 24; k++) begin
         s = 1'($urandom_range(0, 1));
         d = 14'($urandom);
         model(s, d, eb, en, ec);
         run_one(s, d, lat);
         total++;
         if (lat !== 30 || bcd !== eb || neg !== en ||
             clamped !== ec || out_sel !== s) begin
            bad++;
            $display("FAIL rnd%0d sel=%b d=%0d lat=%0d bcd=%h n=%b c=%b exp 30 %h %b %b",
                     k, s, d, lat, bcd, neg, clamped, eb, en, ec);
         end
      end
   endtask

   task automatic test_overrun();
      logic [15:0] eb1, eb3, b1, b3;
      bit en, ec, ov10, ov30, ovx, busy31;
      bit s1, s3;
      int t1, t3, nv;
      model(0, 14'd6000, eb1, en, ec);
      model(1, 14'd1000, eb3, en, ec);
      ov10 = 0; ov30 = 0; ovx = 0; busy31 = 0;
      t1 = -1; t3 = -1; nv = 0;
      b1 = '0; b3 = '0; s1 = 0; s3 = 0;
      strobe(0, 14'd6000);
      for (int i = 1; i <= 64; i++) begin
         @(negedge clock);
         raw_valid = (i == 10 || i == 30 || i == 31);
         raw_sel = (i == 31);
         raw_data = (i == 31) ? 14'd1000 : 14'd100;
         @(posedge clock);
         #1;
         raw_valid = 1'b0;
         if (overrun) begin
            if (i == 10) ov10 = 1;
            else if (i == 30) ov30 = 1;
            else ovx = 1;
         end
         if (i == 31) busy31 = busy;
         if (out_valid) begin
            nv++;
            if (t1 < 0) begin
               t1 = i; b1 = bcd; s1 = out_sel;
            end else begin
               t3 = i; b3 = bcd; s3 = out_sel;
            end
         end
      end
      total++;
      if (!ov10 || !ov30 || ovx) begin
         bad++;
         $display("FAIL ovr_pulses at10=%b at30=%b other=%b exp 1 1 0",
                  ov10, ov30, ovx);
      end
      total++;
      if (t1 !== 30 || b1 !== eb1 || s1 !== 1'b0) begin
         bad++;
         $display("FAIL ovr_first t=%0d bcd=%h sel=%b exp 30 %h 0",
                  t1, b1, s1, eb1);
      end
      total++;
      if (busy31 !== 1'b1) begin
         bad++;
         $display("FAIL ovr_accept31 busy=%b exp=1", busy31);
      end
      total++;
      if (nv !== 2 || t3 !== 61 || b3 !== eb3 || s3 !== 1'b1) begin
         bad++;
         $display("FAIL ovr_third n=%0d t=%0d bcd=%h sel=%b exp 2 61 %h 1",
                  nv, t3, b3, s3, eb3);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ea, eh, ba, bh;
      bit en, ec, sa, sh;
      logic [13:0] da, dh;
      int ta, th, nv;
      da = 14'($urandom);
      dh = 14'($urandom_range(500, 3000));
      model(0, da, ea, en, ec);
      model(1, dh, eh, en, ec);
      ta = -1; th = -1; nv = 0;
      ba = '0; bh = '0; sa = 1; sh = 0;
      strobe(0, da);
      for (int i = 1; i <= 65; i++) begin
         @(negedge clock);
         raw_valid = (i == 31);
         raw_sel = 1'b1;
         raw_data = dh;
         @(posedge clock);
         #1;
         raw_valid = 1'b0;
         if (out_valid) begin
            nv++;
            if (ta < 0) begin
               ta = i; ba = bcd; sa = out_sel;
            end else begin
               th = i; bh = bcd; sh = out_sel;
            end
         end
      end
      total++;
      if (nv !== 2 || th - ta !== 31 || ta !== 30) begin
         bad++;
         $display("FAIL b2b_timing n=%0d t1=%0d t2=%0d exp 2 30 61",
                  nv, ta, th);
      end
      total++;
      if (ba !== ea || sa !== 1'b0 || bh !== eh || sh !== 1'b1) begin
         bad++;
         $display("FAIL b2b_data %h/%b %h/%b exp %h/0 %h/1",
                  ba, sa, bh, sh, ea, eh);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] eb;
      bit en, ec, seen;
      int lat;
      strobe(0, 14'd0);
      repeat (14) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      total++;
      if ({busy, out_valid, overrun, neg, clamped, out_sel} !== 6'b0 ||
          bcd !== 16'h0000) begin
         bad++;
         $display("FAIL midrst_out flags=%b bcd=%h exp 000000 0000",
                  {busy, out_valid, overrun, neg, clamped, out_sel}, bcd);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (out_valid) seen = 1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL midrst_no_valid got=%b exp=0", seen);
      end
      model(0, 14'd6000, eb, en, ec);
      run_one(0, 14'd6000, lat);
      total++;
      if (lat !== 30 || bcd !== eb || neg !== en) begin
         bad++;
         $display("FAIL midrst_after lat=%0d bcd=%h neg=%b exp 30 %h %b",
                  lat, bcd, neg, eb, en);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
